// File: rtl/mvu_sched_pkg.sv
// Shared types and helpers for the MVU activation replay scheduler.
package mvu_sched_pkg;

    typedef enum logic [0:0] {
        StFill,
        StReplay
    } sched_state_e;

    // Counter width for an n-valued counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvu_replay_sched_if.sv
// AXI-Stream style handshake bundle for activation beats.
interface mvu_replay_sched_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mvu_replay_buf.sv
// Single activation-vector store: synchronous write, asynchronous read.
module mvu_replay_buf
    import mvu_sched_pkg::*;
#(
    parameter int unsigned Depth     = 9,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned AddrWidth = cnt_width(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mvu_replay_sched.sv
// Passes one activation vector through to the MVU while storing it, then replays it
// NF-1 more times so every neuron fold sees the full vector.
module mvu_replay_sched
    import mvu_sched_pkg::*;
#(
    parameter int unsigned SF         = 9,
    parameter int unsigned NF         = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          IS_MVU     = 1'b1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    mvu_replay_sched_if.slave         s_axis,
    mvu_replay_sched_if.master        m_axis,
    output logic                      m_axis_tlast,
    output logic                      busy,
    output logic                      vec_done
);

    localparam int unsigned SfW = cnt_width(SF);
    localparam int unsigned NfW = cnt_width(NF);
    localparam bit ReplayEn = IS_MVU && (NF > 1);
    localparam logic [SfW-1:0] SfLast = SfW'(SF - 1);
    localparam logic [NfW-1:0] NfLast = NfW'(NF - 1);

    sched_state_e          state_q, state_d;
    logic [SfW-1:0]        sf_cnt_q, sf_cnt_d;
    logic [NfW-1:0]        nf_cnt_q, nf_cnt_d;
    logic                  vec_done_q, vec_done_d;
    logic                  we;
    logic                  m_valid;
    logic                  sf_last;
    logic [DATA_WIDTH-1:0] rdata;

    mvu_replay_buf #(
        .Depth     (SF),
        .DataWidth (DATA_WIDTH)
    ) u_buf (
        .clk_i   (ap_clk),
        .we_i    (we),
        .waddr_i (sf_cnt_q),
        .wdata_i (s_axis.tdata),
        .raddr_i (sf_cnt_q),
        .rdata_o (rdata)
    );

    assign sf_last = (sf_cnt_q == SfLast);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= StFill;
            sf_cnt_q   <= '0;
            nf_cnt_q   <= '0;
            vec_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sf_cnt_q   <= sf_cnt_d;
            nf_cnt_q   <= nf_cnt_d;
            vec_done_q <= vec_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sf_cnt_d      = sf_cnt_q;
        nf_cnt_d      = nf_cnt_q;
        vec_done_d    = 1'b0;
        we            = 1'b0;
        m_valid       = 1'b0;
        s_axis.tready = 1'b0;
        m_axis.tdata  = s_axis.tdata;

        unique case (state_q)
            StFill: begin
                m_valid       = s_axis.tvalid;
                s_axis.tready = m_axis.tready;
                if (s_axis.tvalid && m_axis.tready) begin
                    we = 1'b1;
                    if (sf_last) begin
                        sf_cnt_d = '0;
                        if (ReplayEn) begin
                            state_d  = StReplay;
                            nf_cnt_d = NfW'(1);
                        end else begin
                            vec_done_d = 1'b1;
                        end
                    end else begin
                        sf_cnt_d = sf_cnt_q + SfW'(1);
                    end
                end
            end
            StReplay: begin
                m_valid      = 1'b1;
                m_axis.tdata = rdata;
                if (m_axis.tready) begin
                    if (sf_last) begin
                        sf_cnt_d = '0;
                        if (nf_cnt_q == NfLast) begin
                            state_d    = StFill;
                            nf_cnt_d   = '0;
                            vec_done_d = 1'b1;
                        end else begin
                            nf_cnt_d = nf_cnt_q + NfW'(1);
                        end
                    end else begin
                        sf_cnt_d = sf_cnt_q + SfW'(1);
                    end
                end
            end
            default: state_d = StFill;
        endcase

        // Handshakes are held off for the whole reset cycle; nothing may be stored.
        if (!ap_rst_n) begin
            we            = 1'b0;
            m_valid       = 1'b0;
            s_axis.tready = 1'b0;
        end
    end

    assign m_axis.tvalid = m_valid;
    assign m_axis_tlast  = m_valid && sf_last;
    assign busy          = (state_q == StReplay);
    assign vec_done      = vec_done_q;

endmodule

// File: tb/tb_mvu_replay_sched.sv
// Randomized bench for mvu_replay_sched: four configurations run side by side against a
// beat-counting reference model (pass p of a vector, beat b within it).
module tb_mvu_replay_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sv [4];
    logic [7:0] sd [4];
    logic       mr [4];
    logic       o_v [4], o_rdy [4], o_last [4], o_busy [4], o_vd [4];
    logic [7:0] o_d [4];

    mvu_replay_sched_if #(.DATA_WIDTH(8)) s0 ();
    mvu_replay_sched_if #(.DATA_WIDTH(8)) s1 ();
    mvu_replay_sched_if #(.DATA_WIDTH(8)) s2 ();
    mvu_replay_sched_if #(.DATA_WIDTH(8)) s3 ();
    mvu_replay_sched_if #(.DATA_WIDTH(8)) m0 ();
    mvu_replay_sched_if #(.DATA_WIDTH(8)) m1 ();
    mvu_replay_sched_if #(.DATA_WIDTH(8)) m2 ();
    mvu_replay_sched_if #(.DATA_WIDTH(8)) m3 ();

    assign s0.tdata = sd[0]; assign s0.tvalid = sv[0]; assign m0.tready = mr[0];
    assign s1.tdata = sd[1]; assign s1.tvalid = sv[1]; assign m1.tready = mr[1];
    assign s2.tdata = sd[2]; assign s2.tvalid = sv[2]; assign m2.tready = mr[2];
    assign s3.tdata = sd[3]; assign s3.tvalid = sv[3]; assign m3.tready = mr[3];
    assign o_v[0] = m0.tvalid; assign o_rdy[0] = s0.tready; assign o_d[0] = m0.tdata;
    assign o_v[1] = m1.tvalid; assign o_rdy[1] = s1.tready; assign o_d[1] = m1.tdata;
    assign o_v[2] = m2.tvalid; assign o_rdy[2] = s2.tready; assign o_d[2] = m2.tdata;
    assign o_v[3] = m3.tvalid; assign o_rdy[3] = s3.tready; assign o_d[3] = m3.tdata;

    mvu_replay_sched #(.SF(4), .NF(3), .DATA_WIDTH(8), .IS_MVU(1'b1)) u0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis(s0), .m_axis(m0),
        .m_axis_tlast(o_last[0]), .busy(o_busy[0]), .vec_done(o_vd[0]));
    mvu_replay_sched #(.SF(4), .NF(1), .DATA_WIDTH(8), .IS_MVU(1'b1)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis(s1), .m_axis(m1),
        .m_axis_tlast(o_last[1]), .busy(o_busy[1]), .vec_done(o_vd[1]));
    mvu_replay_sched #(.SF(4), .NF(3), .DATA_WIDTH(8), .IS_MVU(1'b0)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis(s2), .m_axis(m2),
        .m_axis_tlast(o_last[2]), .busy(o_busy[2]), .vec_done(o_vd[2]));
    mvu_replay_sched #(.SF(1), .NF(2), .DATA_WIDTH(8), .IS_MVU(1'b1)) u3 (
        .ap_clk(clk), .ap_rst_n(rst_n), .s_axis(s3), .m_axis(m3),
        .m_axis_tlast(o_last[3]), .busy(o_busy[3]), .vec_done(o_vd[3]));

    int vectors = 0;
    int miscompares = 0;
    int cyc_no = 0;
    // Beats per vector and total output beats per vector (SF * effective NF).
    int sf_p [4] = '{4, 4, 4, 1};
    int tot_p [4] = '{12, 4, 4, 2};

    int         out_cnt [4];
    logic [7:0] vecm [4][4];
    logic       vd_pend [4];
    logic [7:0] q [4][$];
    logic [7:0] outq [4][$];
    int         vmode [4], rmode [4], pat [4];
    int         xfers [4], vd_cnt [4];
    int         rdy_low0;
    logic [7:0] expv [12];

    task automatic chk(input string tag, input int id, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d cyc%0d: got %0h want %0h", tag, id, cyc_no, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            xfers[i] = 0; vd_cnt[i] = 0; pat[i] = 0;
            outq[i].delete();
        end
        rdy_low0 = 0;
    endtask

    task automatic step(input logic rst_val);
        int  p, b;
        logic fill, ev, erdy, xfer;
        logic [7:0] ed;
        @(negedge clk);
        rst_n = rst_val;
        cyc_no++;
        for (int id = 0; id < 4; id++) begin
            sv[id] = (q[id].size() > 0) && (vmode[id] == 0 || $urandom_range(0, 1) == 1);
            sd[id] = (q[id].size() > 0) ? q[id][0] : 8'($urandom);
            case (rmode[id])
                0: mr[id] = 1'b1;
                1: mr[id] = (pat[id] % 4 == 0) || (pat[id] % 4 == 3);
                default: mr[id] = ($urandom_range(0, 1) == 1);
            endcase
        end
        #1;
        for (int id = 0; id < 4; id++) begin
            if (!rst_val) begin
                chk("rst_tready", id, 32'(o_rdy[id]), 32'd0);
                chk("rst_tvalid", id, 32'(o_v[id]), 32'd0);
                out_cnt[id] = 0;
                vd_pend[id] = 1'b0;
                continue;
            end
            pat[id]++;
            p    = out_cnt[id];
            b    = p % sf_p[id];
            fill = (p < sf_p[id]);
            ev   = fill ? sv[id] : 1'b1;
            erdy = fill ? mr[id] : 1'b0;
            ed   = fill ? sd[id] : vecm[id][b];
            chk("tvalid", id, 32'(o_v[id]), 32'(ev));
            chk("s_tready", id, 32'(o_rdy[id]), 32'(erdy));
            if (ev) chk("tdata", id, 32'(o_d[id]), 32'(ed));
            chk("tlast", id, 32'(o_last[id]), 32'(ev && (b == sf_p[id] - 1)));
            chk("busy", id, 32'(o_busy[id]), 32'(!fill));
            chk("vec_done", id, 32'(o_vd[id]), 32'(vd_pend[id]));
            if (o_vd[id]) vd_cnt[id]++;
            if (id == 0 && xfers[0] < 12 && !o_rdy[0]) rdy_low0++;
            xfer = ev && mr[id];
            if (fill && sv[id] && mr[id]) begin
                vecm[id][b] = sd[id];
                void'(q[id].pop_front());
            end
            vd_pend[id] = 1'b0;
            if (xfer) begin
                xfers[id]++;
                outq[id].push_back(o_d[id]);
                out_cnt[id] = (p + 1) % tot_p[id];
                if (out_cnt[id] == 0) vd_pend[id] = 1'b1;
            end
        end
    endtask

    // Steps until every source queue is empty and every model is between vectors.
    task automatic drain(input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step(1'b1);
            done = 1'b1;
            for (int i = 0; i < 4; i++)
                if (q[i].size() > 0 || out_cnt[i] != 0) done = 1'b0;
        end
        chk("drain_in_budget", 0, 32'(done), 32'd1);
        step(1'b1);
        step(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sv[i] = 1'b0; sd[i] = 8'h00; mr[i] = 1'b0;
            vmode[i] = 0; rmode[i] = 0;
            out_cnt[i] = 0; vd_pend[i] = 1'b0;
        end
        clear_stats();
        step(1'b0);
        step(1'b0);

        // Directed vector plus a 5th beat offered during replay; other configs run random.
        clear_stats();
        q[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 12; i++) q[1].push_back(8'($urandom));
        for (int i = 0; i < 8; i++) q[2].push_back(8'($urandom));
        q[3].push_back(8'h7E);
        for (int i = 0; i < 3; i++) q[3].push_back(8'($urandom));
        for (int i = 1; i < 4; i++) begin vmode[i] = 1; rmode[i] = 2; end
        drain(400);
        chk("xfers_u0", 0, 32'(xfers[0]), 32'd24);
        chk("tready_low_cycles", 0, 32'(rdy_low0), 32'd8);
        chk("vec_done_count", 0, 32'(vd_cnt[0]), 32'd2);
        chk("beat12", 0, 32'(outq[0][11]), 32'h44);
        chk("next_vec_first", 0, 32'(outq[0][12]), 32'h55);
        chk("xfers_nf1", 1, 32'(xfers[1]), 32'd12);
        chk("vec_done_nf1", 1, 32'(vd_cnt[1]), 32'd3);
        chk("xfers_vvu", 2, 32'(xfers[2]), 32'd8);
        chk("vec_done_vvu", 2, 32'(vd_cnt[2]), 32'd2);
        chk("sf1_beat0", 3, 32'(outq[3][0]), 32'h7E);
        chk("sf1_beat1", 3, 32'(outq[3][1]), 32'h7E);
        chk("vec_done_sf1", 3, 32'(vd_cnt[3]), 32'd4);

        // Random source valid against a 1,0,0,1 sink ready pattern.
        step(1'b0);
        clear_stats();
        for (int i = 1; i < 4; i++) begin vmode[i] = 0; rmode[i] = 0; end
        vmode[0] = 1; rmode[0] = 1;
        q[0] = '{8'h11, 8'h22, 8'h33, 8'h44};
        expv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h11, 8'h22, 8'h33, 8'h44};
        drain(400);
        chk("stall_count", 0, 32'(outq[0].size()), 32'd12);
        for (int i = 0; i < 12 && i < outq[0].size(); i++)
            chk("stall_seq", 0, 32'(outq[0][i]), 32'(expv[i]));
        chk("stall_vec_done", 0, 32'(vd_cnt[0]), 32'd1);

        // Reset after beat 6 of 12; next accepted beat starts a fresh vector.
        step(1'b0);
        clear_stats();
        vmode[0] = 0; rmode[0] = 0;
        q[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int n = 0; n < 50 && xfers[0] < 6; n++) step(1'b1);
        chk("pre_reset_beats", 0, 32'(xfers[0]), 32'd6);
        step(1'b0);
        clear_stats();
        expv = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        drain(400);
        chk("post_reset_count", 0, 32'(outq[0].size()), 32'd12);
        for (int i = 0; i < 12 && i < outq[0].size(); i++)
            chk("post_reset_seq", 0, 32'(outq[0][i]), 32'(expv[i]));
        chk("post_reset_vec_done", 0, 32'(vd_cnt[0]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
